// File: rtl/ex.sv
// ---------------------------------------------------------------------------
// ex : execute stage of the five-stage MIPS pipeline (decode -> ex -> mem).
//
// Computes ALU/shift/LUI results, performs MULT/MULTU in a single cycle,
// owns the HI/LO registers and, when the EX_DIV_EN macro is defined, runs
// DIV/DIVU on an iterative radix-2 restoring divider. Every value consumed
// by mem is registered here.
//
// Build option:
//   EX_DIV_EN  defined   -> divider FSM present (IDLE/BUSY/DONE).
//              undefined -> ops 14/15 behave as NOP, ex_stall_o is 0.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   ex_inst_i/_pc_i     instruction word and PC from decode
//   ex_inslot_i         instruction sits in a delay slot
//   ex_memop_i [3:0]    memory op code, passed through to mem
//   ex_aluop_i [4:0]    operation select
//   ex_src1_i/_src2_i   forwarded operands
//   ex_waddr_i/_wren_i  destination register and write enable
//   ex_nofwd_i          result not forwardable (loads)
//   ex_stall_i          downstream/global stall (hold outputs)
//   ex_flush_i          flush (clear outputs, abort divide)
//   ex_*_o              registered copies for mem; ex_wdata_o = result
//   ex_stall_o          combinational upstream freeze request
// ---------------------------------------------------------------------------
module ex (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] ex_inst_i,
   input  logic [31:0] ex_pc_i,
   input  logic        ex_inslot_i,
   input  logic [3:0]  ex_memop_i,
   input  logic [4:0]  ex_aluop_i,
   input  logic [31:0] ex_src1_i,
   input  logic [31:0] ex_src2_i,
   input  logic [4:0]  ex_waddr_i,
   input  logic        ex_wren_i,
   input  logic        ex_nofwd_i,
   input  logic        ex_stall_i,
   input  logic        ex_flush_i,
   output logic [31:0] ex_inst_o,
   output logic [31:0] ex_pc_o,
   output logic        ex_inslot_o,
   output logic        ex_wren_o,
   output logic        ex_nofwd_o,
   output logic [3:0]  ex_memop_o,
   output logic [4:0]  ex_waddr_o,
   output logic [31:0] ex_wdata_o,
   output logic        ex_stall_o
);

   localparam logic [4:0] OP_ADD   = 5'd1;
   localparam logic [4:0] OP_SUB   = 5'd2;
   localparam logic [4:0] OP_AND   = 5'd3;
   localparam logic [4:0] OP_OR    = 5'd4;
   localparam logic [4:0] OP_XOR   = 5'd5;
   localparam logic [4:0] OP_NOR   = 5'd6;
   localparam logic [4:0] OP_SLT   = 5'd7;
   localparam logic [4:0] OP_SLTU  = 5'd8;
   localparam logic [4:0] OP_SLL   = 5'd9;
   localparam logic [4:0] OP_SRL   = 5'd10;
   localparam logic [4:0] OP_SRA   = 5'd11;
   localparam logic [4:0] OP_MULT  = 5'd12;
   localparam logic [4:0] OP_MULTU = 5'd13;
`ifdef EX_DIV_EN
   localparam logic [4:0] OP_DIV   = 5'd14;
   localparam logic [4:0] OP_DIVU  = 5'd15;
`endif
   localparam logic [4:0] OP_MFHI  = 5'd16;
   localparam logic [4:0] OP_MFLO  = 5'd17;
   localparam logic [4:0] OP_MTHI  = 5'd18;
   localparam logic [4:0] OP_MTLO  = 5'd19;
   localparam logic [4:0] OP_LUI   = 5'd20;

   logic [31:0] hi_q, lo_q;
   logic [31:0] result_d;
   logic [63:0] op1_x, op2_x, prod;
   logic        mul_sgn;
   logic        accept;

   logic [31:0] inst_q, pc_q, wdata_q;
   logic        inslot_q, wren_q, nofwd_q;
   logic [3:0]  memop_q;
   logic [4:0]  waddr_q;

   // ------------------------------------------------------------------
   // Result datapath
   // ------------------------------------------------------------------
   always_comb begin
      mul_sgn = (ex_aluop_i == OP_MULT);
      // Sign- or zero-extend to 64 bits so one multiplier serves both.
      op1_x   = {{32{mul_sgn & ex_src1_i[31]}}, ex_src1_i};
      op2_x   = {{32{mul_sgn & ex_src2_i[31]}}, ex_src2_i};
      prod    = op1_x * op2_x;

      result_d = '0;
      case (ex_aluop_i)
         OP_ADD:  result_d = ex_src1_i + ex_src2_i;
         OP_SUB:  result_d = ex_src1_i - ex_src2_i;
         OP_AND:  result_d = ex_src1_i & ex_src2_i;
         OP_OR:   result_d = ex_src1_i | ex_src2_i;
         OP_XOR:  result_d = ex_src1_i ^ ex_src2_i;
         OP_NOR:  result_d = ~(ex_src1_i | ex_src2_i);
         OP_SLT:  result_d = {31'b0, $signed(ex_src1_i) < $signed(ex_src2_i)};
         OP_SLTU: result_d = {31'b0, ex_src1_i < ex_src2_i};
         OP_SLL:  result_d = ex_src2_i << ex_src1_i[4:0];
         OP_SRL:  result_d = ex_src2_i >> ex_src1_i[4:0];
         OP_SRA:  result_d = $signed(ex_src2_i) >>> ex_src1_i[4:0];
         OP_MFHI: result_d = hi_q;
         OP_MFLO: result_d = lo_q;
         OP_LUI:  result_d = {ex_src2_i[15:0], 16'h0000};
         default: result_d = '0;
      endcase
   end

`ifdef EX_DIV_EN
   // ------------------------------------------------------------------
   // Iterative radix-2 restoring divider on operand magnitudes
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_e;

   div_state_e  state_q;
   logic [4:0]  cnt_q;
   logic [31:0] quo_q, rem_q, dsr_q;
   logic        qneg_q, rneg_q;

   logic        is_div, div_sgn, s1neg, s2neg, q_bit;
   logic [31:0] mag1, mag2, rem_diff, rem_nx, quo_fin, rem_fin;
   logic [32:0] rem_sh;

   always_comb begin
      is_div  = (ex_aluop_i == OP_DIV) || (ex_aluop_i == OP_DIVU);
      div_sgn = (ex_aluop_i == OP_DIV);
      s1neg   = div_sgn & ex_src1_i[31];
      s2neg   = div_sgn & ex_src2_i[31];
      mag1    = s1neg ? -ex_src1_i : ex_src1_i;
      mag2    = s2neg ? -ex_src2_i : ex_src2_i;

      // quo_q doubles as the dividend shift register; quotient bits
      // enter at the bottom as dividend bits leave at the top.
      rem_sh   = {rem_q, quo_q[31]};
      rem_diff = rem_sh[31:0] - dsr_q;
      q_bit    = (rem_sh >= {1'b0, dsr_q});
      rem_nx   = q_bit ? rem_diff : rem_sh[31:0];

      quo_fin  = qneg_q ? -quo_q : quo_q;
      rem_fin  = rneg_q ? -rem_q : rem_q;
   end

   assign ex_stall_o = ((state_q == S_IDLE) && is_div && !ex_flush_i) ||
                       (state_q == S_BUSY);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dsr_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
      end else if (ex_flush_i) begin
         state_q <= S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (is_div) begin
                  state_q <= S_BUSY;
                  cnt_q   <= '0;
                  quo_q   <= mag1;
                  rem_q   <= '0;
                  dsr_q   <= mag2;
                  // A zero divisor leaves an all-ones magnitude quotient;
                  // suppressing negation yields LO=0xFFFFFFFF, and the
                  // remainder path already restores the original dividend.
                  qneg_q  <= (s1neg ^ s2neg) & (ex_src2_i != '0);
                  rneg_q  <= s1neg;
               end
            end
            S_BUSY: begin
               quo_q <= {quo_q[30:0], q_bit};
               rem_q <= rem_nx;
               if (cnt_q == 5'd31) state_q <= S_DONE;
               else                cnt_q   <= cnt_q + 5'd1;
            end
            S_DONE: begin
               if (!ex_stall_i) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
`else
   assign ex_stall_o = 1'b0;
`endif

   assign accept = !ex_stall_i && !ex_flush_i && !ex_stall_o;

   // ------------------------------------------------------------------
   // HI/LO: side effects only on the accepting edge
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (accept) begin
         case (ex_aluop_i)
            OP_MULT, OP_MULTU: begin
               hi_q <= prod[63:32];
               lo_q <= prod[31:0];
            end
            OP_MTHI: hi_q <= ex_src1_i;
            OP_MTLO: lo_q <= ex_src1_i;
`ifdef EX_DIV_EN
            // A divide is only accepted from DONE (stall_o masks IDLE).
            OP_DIV, OP_DIVU: begin
               if (state_q == S_DONE) begin
                  hi_q <= rem_fin;
                  lo_q <= quo_fin;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Output register: flush > hold > bubble > load
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inst_q   <= '0;
         pc_q     <= '0;
         inslot_q <= 1'b0;
         memop_q  <= '0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         wren_q   <= 1'b0;
         nofwd_q  <= 1'b0;
      end else if (ex_flush_i || (!ex_stall_i && ex_stall_o)) begin
         inst_q   <= '0;
         pc_q     <= '0;
         inslot_q <= 1'b0;
         memop_q  <= '0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         wren_q   <= 1'b0;
         nofwd_q  <= 1'b0;
      end else if (!ex_stall_i) begin
         inst_q   <= ex_inst_i;
         pc_q     <= ex_pc_i;
         inslot_q <= ex_inslot_i;
         memop_q  <= ex_memop_i;
         waddr_q  <= ex_waddr_i;
         wdata_q  <= result_d;
         wren_q   <= ex_wren_i;
         nofwd_q  <= ex_nofwd_i;
      end
   end

   assign ex_inst_o   = inst_q;
   assign ex_pc_o     = pc_q;
   assign ex_inslot_o = inslot_q;
   assign ex_memop_o  = memop_q;
   assign ex_waddr_o  = waddr_q;
   assign ex_wdata_o  = wdata_q;
   assign ex_wren_o   = wren_q;
   assign ex_nofwd_o  = nofwd_q;

endmodule

// File: tb/tb_ex.sv
// ---------------------------------------------------------------------------
// tb_ex : directed self-checking bench for the ex execute stage.
// Covers the divider when EX_DIV_EN is defined, NOP behaviour of ops 14/15
// otherwise.
// ---------------------------------------------------------------------------
module tb_ex;

   localparam logic [4:0] OP_NOP   = 5'd0;
   localparam logic [4:0] OP_ADD   = 5'd1;
   localparam logic [4:0] OP_SUB   = 5'd2;
   localparam logic [4:0] OP_AND   = 5'd3;
   localparam logic [4:0] OP_OR    = 5'd4;
   localparam logic [4:0] OP_XOR   = 5'd5;
   localparam logic [4:0] OP_NOR   = 5'd6;
   localparam logic [4:0] OP_SLT   = 5'd7;
   localparam logic [4:0] OP_SLTU  = 5'd8;
   localparam logic [4:0] OP_SLL   = 5'd9;
   localparam logic [4:0] OP_SRL   = 5'd10;
   localparam logic [4:0] OP_SRA   = 5'd11;
   localparam logic [4:0] OP_MULT  = 5'd12;
   localparam logic [4:0] OP_MULTU = 5'd13;
   localparam logic [4:0] OP_DIV   = 5'd14;
   localparam logic [4:0] OP_DIVU  = 5'd15;
   localparam logic [4:0] OP_MFHI  = 5'd16;
   localparam logic [4:0] OP_MFLO  = 5'd17;
   localparam logic [4:0] OP_MTHI  = 5'd18;
   localparam logic [4:0] OP_MTLO  = 5'd19;
   localparam logic [4:0] OP_LUI   = 5'd20;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] ex_inst_i, ex_pc_i, ex_src1_i, ex_src2_i;
   logic        ex_inslot_i, ex_wren_i, ex_nofwd_i, ex_stall_i, ex_flush_i;
   logic [3:0]  ex_memop_i;
   logic [4:0]  ex_aluop_i, ex_waddr_i;
   logic [31:0] ex_inst_o, ex_pc_o, ex_wdata_o;
   logic        ex_inslot_o, ex_wren_o, ex_nofwd_o, ex_stall_o;
   logic [3:0]  ex_memop_o;
   logic [4:0]  ex_waddr_o;

   int checks   = 0;
   int failures = 0;

   ex dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ex_inst_i   (ex_inst_i),
      .ex_pc_i     (ex_pc_i),
      .ex_inslot_i (ex_inslot_i),
      .ex_memop_i  (ex_memop_i),
      .ex_aluop_i  (ex_aluop_i),
      .ex_src1_i   (ex_src1_i),
      .ex_src2_i   (ex_src2_i),
      .ex_waddr_i  (ex_waddr_i),
      .ex_wren_i   (ex_wren_i),
      .ex_nofwd_i  (ex_nofwd_i),
      .ex_stall_i  (ex_stall_i),
      .ex_flush_i  (ex_flush_i),
      .ex_inst_o   (ex_inst_o),
      .ex_pc_o     (ex_pc_o),
      .ex_inslot_o (ex_inslot_o),
      .ex_wren_o   (ex_wren_o),
      .ex_nofwd_o  (ex_nofwd_o),
      .ex_memop_o  (ex_memop_o),
      .ex_waddr_o  (ex_waddr_o),
      .ex_wdata_o  (ex_wdata_o),
      .ex_stall_o  (ex_stall_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wa, input logic we);
      ex_aluop_i = op;
      ex_src1_i  = a;
      ex_src2_i  = b;
      ex_waddr_i = wa;
      ex_wren_i  = we;
      ex_inst_i  = {27'h0, op};
      ex_pc_i    = 32'h0000_4000 + {27'h0, op};
      #1;
   endtask

   task automatic alu(input string tag, input logic [4:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
      drive(op, a, b, 5'd1, 1'b1);
      tick();
      chk(tag, ex_wdata_o, exp);
   endtask

`ifdef EX_DIV_EN
   // Clock through a divide while stall_o is high; outputs must carry ew/ewr.
   task automatic div_wait(input logic [31:0] ew, input logic ewr, output int n);
      n = 0;
      while (ex_stall_o === 1'b1 && n < 100) begin
         tick();
         n++;
         chk("div_busy_wdata", ex_wdata_o, ew);
         chk("div_busy_wren", {31'b0, ex_wren_o}, {31'b0, ewr});
      end
   endtask
`endif

   initial begin
`ifdef EX_DIV_EN
      int n;
`endif
      rst_n       = 1'b0;
      ex_inst_i   = '0;
      ex_pc_i     = '0;
      ex_src1_i   = '0;
      ex_src2_i   = '0;
      ex_inslot_i = 1'b0;
      ex_wren_i   = 1'b0;
      ex_nofwd_i  = 1'b0;
      ex_stall_i  = 1'b0;
      ex_flush_i  = 1'b0;
      ex_memop_i  = '0;
      ex_aluop_i  = '0;
      ex_waddr_i  = '0;

      // Reset state
      #3;
      chk("rst_wdata", ex_wdata_o, 32'h0);
      chk("rst_pc", ex_pc_o, 32'h0);
      chk("rst_wren", {31'b0, ex_wren_o}, 32'h0);
      chk("rst_stall", {31'b0, ex_stall_o}, 32'h0);
      #9;
      rst_n = 1'b1;

      // ADD wraps without trap, sideband passes through
      ex_inslot_i = 1'b1;
      ex_memop_i  = 4'h5;
      ex_nofwd_i  = 1'b1;
      drive(OP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd3, 1'b1);
      chk("add_stall", {31'b0, ex_stall_o}, 32'h0);
      tick();
      chk("add_wdata", ex_wdata_o, 32'h8000_0000);
      chk("add_waddr", {27'b0, ex_waddr_o}, 32'd3);
      chk("add_wren", {31'b0, ex_wren_o}, 32'd1);
      chk("add_inst", ex_inst_o, 32'h1);
      chk("add_pc", ex_pc_o, 32'h0000_4001);
      chk("add_inslot", {31'b0, ex_inslot_o}, 32'd1);
      chk("add_memop", {28'b0, ex_memop_o}, 32'h5);
      chk("add_nofwd", {31'b0, ex_nofwd_o}, 32'd1);
      ex_inslot_i = 1'b0;
      ex_memop_i  = '0;
      ex_nofwd_i  = 1'b0;

      // ALU / shift / LUI vectors
      alu("sub",  OP_SUB,  32'h5,         32'h7,          32'hFFFF_FFFE);
      alu("and",  OP_AND,  32'hF0F0_FF00, 32'h0FF0_F0F0,  32'h00F0_F000);
      alu("or",   OP_OR,   32'hF0F0_0000, 32'h0000_000F,  32'hF0F0_000F);
      alu("xor",  OP_XOR,  32'hFFFF_0000, 32'hF0F0_F0F0,  32'h0F0F_F0F0);
      alu("nor",  OP_NOR,  32'hFFFF_0000, 32'h0000_00FF,  32'h0000_FF00);
      alu("slt",  OP_SLT,  32'hFFFF_FFFF, 32'h1,          32'h1);
      alu("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'h1,          32'h0);
      alu("sll",  OP_SLL,  32'h3F,        32'h1,          32'h8000_0000);
      alu("srl",  OP_SRL,  32'h4,         32'h8000_0000,  32'h0800_0000);
      alu("sra",  OP_SRA,  32'h4,         32'h8000_0000,  32'hF800_0000);
      alu("lui",  OP_LUI,  32'h0,         32'hABCD_1234,  32'h1234_0000);
      alu("nop",  OP_NOP,  32'h5,         32'h6,          32'h0);
      alu("op25", 5'd25,   32'h5,         32'h6,          32'h0);

      // MULT / MULTU / MT* / MF*
      alu("mult_res",  OP_MULT,  32'hFFFF_FFFF, 32'h2, 32'h0);
      alu("mult_hi",   OP_MFHI,  32'h0, 32'h0, 32'hFFFF_FFFF);
      alu("mult_lo",   OP_MFLO,  32'h0, 32'h0, 32'hFFFF_FFFE);
      alu("multu_res", OP_MULTU, 32'hFFFF_FFFF, 32'h2, 32'h0);
      alu("multu_hi",  OP_MFHI,  32'h0, 32'h0, 32'h1);
      alu("multu_lo",  OP_MFLO,  32'h0, 32'h0, 32'hFFFF_FFFE);
      alu("mthi_res",  OP_MTHI,  32'h1111, 32'h0, 32'h0);
      alu("mtlo_res",  OP_MTLO,  32'h2222, 32'h0, 32'h0);
      alu("mthi_rd",   OP_MFHI,  32'h0, 32'h0, 32'h1111);
      alu("mtlo_rd",   OP_MFLO,  32'h0, 32'h0, 32'h2222);

      // Stall hold: outputs frozen, MTHI does not commit
      drive(OP_ADD, 32'h1, 32'h1, 5'd9, 1'b1);
      tick();
      chk("pre_stall_wdata", ex_wdata_o, 32'h2);
      ex_stall_i = 1'b1;
      drive(OP_MTHI, 32'hDEAD, 32'h0, 5'd10, 1'b1);
      tick();
      chk("stall_hold_wdata", ex_wdata_o, 32'h2);
      chk("stall_hold_waddr", {27'b0, ex_waddr_o}, 32'd9);
      ex_stall_i = 1'b0;
      alu("stall_no_commit", OP_MFHI, 32'h0, 32'h0, 32'h1111);

      // Flush clears outputs
      ex_flush_i = 1'b1;
      drive(OP_ADD, 32'h1, 32'h1, 5'd12, 1'b1);
      tick();
      chk("flush_wdata", ex_wdata_o, 32'h0);
      chk("flush_wren", {31'b0, ex_wren_o}, 32'h0);
      chk("flush_waddr", {27'b0, ex_waddr_o}, 32'h0);
      chk("flush_pc", ex_pc_o, 32'h0);
      ex_flush_i = 1'b0;

`ifdef EX_DIV_EN
      // DIV -7 / 2 -> LO=-3, HI=-1
      drive(OP_DIV, 32'hFFFF_FFF9, 32'h2, 5'd8, 1'b1);
      div_wait(32'h0, 1'b0, n);
      chk("div_stall_cycles", 32'(n), 32'd33);
      chk("div_done_stall", {31'b0, ex_stall_o}, 32'h0);
      tick();
      drive(OP_MFLO, 32'h0, 32'h0, 5'd1, 1'b1);
      chk("div_out_wdata", ex_wdata_o, 32'h0);
      chk("div_out_waddr", {27'b0, ex_waddr_o}, 32'd8);
      chk("div_out_wren", {31'b0, ex_wren_o}, 32'd1);
      chk("div_no_restart", {31'b0, ex_stall_o}, 32'h0);
      tick();
      chk("div_lo", ex_wdata_o, 32'hFFFF_FFFD);
      alu("div_hi", OP_MFHI, 32'h0, 32'h0, 32'hFFFF_FFFF);

      // DIVU by zero -> LO=all ones, HI=dividend, same latency
      drive(OP_DIVU, 32'h1234, 32'h0, 5'd0, 1'b0);
      div_wait(32'h0, 1'b0, n);
      chk("divz_stall_cycles", 32'(n), 32'd33);
      tick();
      alu("divz_lo", OP_MFLO, 32'h0, 32'h0, 32'hFFFF_FFFF);
      alu("divz_hi", OP_MFHI, 32'h0, 32'h0, 32'h1234);

      // Flush at BUSY counter=10 aborts without touching HI/LO
      drive(OP_DIV, 32'd50, 32'd3, 5'd0, 1'b0);
      repeat (11) tick();
      chk("flushdiv_busy", {31'b0, ex_stall_o}, 32'h1);
      ex_flush_i = 1'b1;
      tick();
      chk("flushdiv_wdata", ex_wdata_o, 32'h0);
      chk("flushdiv_wren", {31'b0, ex_wren_o}, 32'h0);
      chk("flushdiv_idle", {31'b0, ex_stall_o}, 32'h0);
      ex_flush_i = 1'b0;
      alu("flushdiv_lo", OP_MFLO, 32'h0, 32'h0, 32'hFFFF_FFFF);
      alu("flushdiv_hi", OP_MFHI, 32'h0, 32'h0, 32'h1234);

      // DONE held by ex_stall_i: outputs hold, no restart, commit on release
      drive(OP_ADD, 32'd3, 32'd4, 5'd5, 1'b1);
      tick();
      chk("pre_done_wdata", ex_wdata_o, 32'd7);
      ex_stall_i = 1'b1;
      drive(OP_DIV, 32'hFFFF_FF9C, 32'd7, 5'd6, 1'b1);
      div_wait(32'd7, 1'b1, n);
      chk("dhold_stall_cycles", 32'(n), 32'd33);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("dhold_stall_o", {31'b0, ex_stall_o}, 32'h0);
         chk("dhold_wdata", ex_wdata_o, 32'd7);
         chk("dhold_waddr", {27'b0, ex_waddr_o}, 32'd5);
      end
      ex_stall_i = 1'b0;
      #1;
      tick();
      drive(OP_MFLO, 32'h0, 32'h0, 5'd2, 1'b1);
      chk("dhold_out_wdata", ex_wdata_o, 32'h0);
      chk("dhold_out_waddr", {27'b0, ex_waddr_o}, 32'd6);
      chk("dhold_no_restart", {31'b0, ex_stall_o}, 32'h0);
      tick();
      chk("dhold_lo", ex_wdata_o, 32'hFFFF_FFF2);
      alu("dhold_hi", OP_MFHI, 32'h0, 32'h0, 32'hFFFF_FFFE);
`else
      // Without the divider, ops 14/15 are NOPs that keep wren
      drive(OP_DIV, 32'd100, 32'd7, 5'd7, 1'b1);
      chk("nodiv_stall", {31'b0, ex_stall_o}, 32'h0);
      tick();
      chk("nodiv_wdata", ex_wdata_o, 32'h0);
      chk("nodiv_waddr", {27'b0, ex_waddr_o}, 32'd7);
      chk("nodiv_wren", {31'b0, ex_wren_o}, 32'd1);
      drive(OP_DIVU, 32'h1234, 32'h0, 5'd8, 1'b1);
      chk("nodivu_stall", {31'b0, ex_stall_o}, 32'h0);
      tick();
      chk("nodivu_wdata", ex_wdata_o, 32'h0);
      alu("nodiv_lo", OP_MFLO, 32'h0, 32'h0, 32'h2222);
      alu("nodiv_hi", OP_MFHI, 32'h0, 32'h0, 32'h1111);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
